// File: rtl/adder_stim_checker.sv
// adder_stim_checker: drives operand vectors into a 4-bit adder and checks its 7-bit result
// against a LATENCY-delayed expected sum, reporting a saturating error count and pass/done.
// Optional: define FIRST_ERR_CAPTURE_EN to add capture of the first mismatching vector per run.
module adder_stim_checker #(
    parameter int LATENCY = 1,    // cycles from valid-high to c sampled (1..8)
    parameter int NUM_VEC = 256,  // vectors per run (1..65535)
    parameter int GAP     = 0     // idle cycles between vectors (0..15)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    output logic [3:0]  a,
    output logic [3:0]  b,
    output logic        valid,
    input  logic [6:0]  c,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_cnt,
    output logic        pass
`ifdef FIRST_ERR_CAPTURE_EN
    ,
    output logic        first_err_vld,
    output logic [3:0]  first_err_a,
    output logic [3:0]  first_err_b,
    output logic [6:0]  first_err_c
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // One delay-line slot: a vector in flight towards its check cycle.
    typedef struct packed {
        logic       vld;
`ifdef FIRST_ERR_CAPTURE_EN
        logic [3:0] a;
        logic [3:0] b;
`endif
        logic [6:0] exp;
    } dly_t;

    localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    state_t      r_state;
    logic        r_mode;
    logic [15:0] r_idx;
    logic [7:0]  r_lfsr;
    logic [3:0]  r_gap;
    logic [3:0]  r_drain;
    logic [3:0]  r_a;
    logic [3:0]  r_b;
    logic        r_valid;
    logic        r_done;
    logic [15:0] r_err_cnt;
`ifdef FIRST_ERR_CAPTURE_EN
    logic        r_fe_vld;
    logic [3:0]  r_fe_a;
    logic [3:0]  r_fe_b;
    logic [6:0]  r_fe_c;
`endif
    dly_t        r_dly [LATENCY];

    logic        w_accept;
    logic        w_sel_lfsr;
    logic [7:0]  w_sel_idx;
    logic [7:0]  w_sel_l;
    logic [3:0]  w_vec_a;
    logic [3:0]  w_vec_b;
    logic [6:0]  w_exp;
    dly_t        w_dly_in;
    dly_t        w_chk;
    logic        w_mismatch;

    // Start is only honoured when no run is in progress.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Next vector source: on an accepted start the first vector comes from the fresh
    // mode input and a reset index/seed, otherwise from the running generator state.
    always_comb begin
        w_sel_lfsr = r_mode;
        w_sel_idx  = r_idx[7:0];
        w_sel_l    = r_lfsr;
        if (w_accept) begin
            w_sel_lfsr = mode;
            w_sel_idx  = 8'h00;
            w_sel_l    = 8'h01;
        end
        w_vec_a = w_sel_lfsr ? w_sel_l[3:0] : w_sel_idx[3:0];
        w_vec_b = w_sel_lfsr ? w_sel_l[7:4] : w_sel_idx[7:4];
    end

    // Expected sum of the operands currently on the bus, at full result width.
    assign w_exp = {3'b000, r_a} + {3'b000, r_b};

    always_comb begin
        w_dly_in     = '0;
        w_dly_in.vld = r_valid;
`ifdef FIRST_ERR_CAPTURE_EN
        w_dly_in.a   = r_a;
        w_dly_in.b   = r_b;
`endif
        w_dly_in.exp = w_exp;
    end

    assign w_chk      = r_dly[LATENCY-1];
    assign w_mismatch = w_chk.vld && (c != w_chk.exp);

    // Delay line aligning each issued vector's expected sum with its result cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) r_dly[i] <= '0;
        end else begin
            r_dly[0] <= w_dly_in;
            for (int i = 1; i < LATENCY; i++) r_dly[i] <= r_dly[i-1];
        end
    end

    // Run control FSM with registered stimulus outputs and the result checker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_idx     <= '0;
            r_lfsr    <= 8'h01;
            r_gap     <= '0;
            r_drain   <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_err_cnt <= '0;
`ifdef FIRST_ERR_CAPTURE_EN
            r_fe_vld  <= 1'b0;
            r_fe_a    <= '0;
            r_fe_b    <= '0;
            r_fe_c    <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                // New run: clear results and issue vector 0 immediately.
                r_mode    <= mode;
                r_err_cnt <= '0;
                r_done    <= 1'b0;
`ifdef FIRST_ERR_CAPTURE_EN
                r_fe_vld  <= 1'b0;
                r_fe_a    <= '0;
                r_fe_b    <= '0;
                r_fe_c    <= '0;
`endif
                r_a       <= w_vec_a;
                r_b       <= w_vec_b;
                r_valid   <= 1'b1;
                r_idx     <= 16'd1;
                r_lfsr    <= lfsr_next(8'h01);
                r_gap     <= 4'(GAP);
                r_drain   <= 4'(LATENCY);
                r_state   <= (NUM_VEC == 1) ? S_DRAIN : S_RUN;
            end else begin
                // Checks can coincide with issue of the final vector; both proceed.
                if (w_mismatch) begin
                    if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
`ifdef FIRST_ERR_CAPTURE_EN
                    if (!r_fe_vld) begin
                        r_fe_vld <= 1'b1;
                        r_fe_a   <= w_chk.a;
                        r_fe_b   <= w_chk.b;
                        r_fe_c   <= c;
                    end
`endif
                end
                case (r_state)
                    S_RUN: begin
                        if (r_gap == 4'd0) begin
                            r_a     <= w_vec_a;
                            r_b     <= w_vec_b;
                            r_valid <= 1'b1;
                            r_idx   <= r_idx + 16'd1;
                            r_lfsr  <= lfsr_next(r_lfsr);
                            r_gap   <= 4'(GAP);
                            if (r_idx == LAST_IDX) begin
                                r_state <= S_DRAIN;
                                r_drain <= 4'(LATENCY);
                            end
                        end else begin
                            r_gap <= r_gap - 4'd1;
                        end
                    end
                    S_DRAIN: begin
                        // Counter hits zero in the cycle the last result is checked.
                        if (r_drain == 4'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_drain <= r_drain - 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign a       = r_a;
    assign b       = r_b;
    assign valid   = r_valid;
    assign busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done    = r_done;
    assign err_cnt = r_err_cnt;
    assign pass    = r_done && (r_err_cnt == 16'd0);
`ifdef FIRST_ERR_CAPTURE_EN
    assign first_err_vld = r_fe_vld;
    assign first_err_a   = r_fe_a;
    assign first_err_b   = r_fe_b;
    assign first_err_c   = r_fe_c;
`endif

endmodule

// File: tb/tb_adder_stim_checker.sv
// Bench for adder_stim_checker: three instances with different LATENCY/NUM_VEC/GAP,
// each closed around a behavioural adder model with selectable delay and stuck-at-0 faults.
module tb_adder_stim_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint req);
        nchk++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, req, req);
        end
    endtask

    // Spec-level vector rule: returns {b,a} of vector k of a run.
    function automatic logic [7:0] ref_vec(input logic m, input int k);
        logic [7:0] l;
        l = 8'h01;
        if (!m) return k[7:0];
        for (int i = 0; i < k; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l;
    endfunction

    function automatic logic [6:0] vsum(input logic [7:0] v);
        return 7'(v[3:0]) + 7'(v[7:4]);
    endfunction

    // ---------------- instance 0: LATENCY=1, NUM_VEC=256, GAP=0 ----------------
    logic rst0 = 1'b0, start0 = 1'b0, mode0 = 1'b0;
    logic [3:0] a0, b0;
    logic valid0, busy0, done0, pass0;
    logic [6:0] c0, pipe0 = '0, mask0 = '0;
    logic [15:0] err0;
`ifdef FIRST_ERR_CAPTURE_EN
    logic fev0; logic [3:0] fea0, feb0; logic [6:0] fec0;
`endif

    adder_stim_checker #(.LATENCY(1), .NUM_VEC(256), .GAP(0)) u0 (
        .clk(clk), .rst(rst0), .start(start0), .mode(mode0),
        .a(a0), .b(b0), .valid(valid0), .c(c0),
        .busy(busy0), .done(done0), .err_cnt(err0), .pass(pass0)
`ifdef FIRST_ERR_CAPTURE_EN
        , .first_err_vld(fev0), .first_err_a(fea0), .first_err_b(feb0), .first_err_c(fec0)
`endif
    );

    always @(posedge clk) pipe0 <= 7'(a0) + 7'(b0);
    assign c0 = pipe0 & ~mask0;

    logic md0 = 1'b0; int nv0 = 0; int lv0 = 0;
    always @(negedge clk) begin : mon0
        logic [7:0] v;
        if (valid0) begin
            v = ref_vec(md0, nv0);
            chk("u0 vec a", a0, v[3:0]);
            chk("u0 vec b", b0, v[7:4]);
            if (nv0 > 0) chk("u0 spacing", cyc - lv0, 1);
            lv0 = cyc;
            nv0++;
        end
    end

    // ---------------- instance 1: LATENCY=1, NUM_VEC=5, GAP=2 ----------------
    logic rst1 = 1'b0, start1 = 1'b0, mode1 = 1'b0;
    logic [3:0] a1, b1;
    logic valid1, busy1, done1, pass1;
    logic [6:0] c1, pipe1 = '0;
    logic [15:0] err1;
`ifdef FIRST_ERR_CAPTURE_EN
    logic fev1; logic [3:0] fea1, feb1; logic [6:0] fec1;
`endif

    adder_stim_checker #(.LATENCY(1), .NUM_VEC(5), .GAP(2)) u1 (
        .clk(clk), .rst(rst1), .start(start1), .mode(mode1),
        .a(a1), .b(b1), .valid(valid1), .c(c1),
        .busy(busy1), .done(done1), .err_cnt(err1), .pass(pass1)
`ifdef FIRST_ERR_CAPTURE_EN
        , .first_err_vld(fev1), .first_err_a(fea1), .first_err_b(feb1), .first_err_c(fec1)
`endif
    );

    always @(posedge clk) pipe1 <= 7'(a1) + 7'(b1);
    assign c1 = pipe1;

    logic md1 = 1'b0; int nv1 = 0; int lv1 = 0;
    logic [7:0] cap1 [5];
    always @(negedge clk) begin : mon1
        logic [7:0] v;
        if (valid1) begin
            v = ref_vec(md1, nv1);
            chk("u1 vec", {b1, a1}, v);
            if (nv1 > 0) chk("u1 spacing", cyc - lv1, 3);
            if (nv1 < 5) cap1[nv1] = {b1, a1};
            lv1 = cyc;
            nv1++;
        end
    end

    // ---------------- instance 2: LATENCY=3, NUM_VEC=64, GAP=0 ----------------
    logic rst2 = 1'b0, start2 = 1'b0, mode2 = 1'b0;
    logic [3:0] a2, b2;
    logic valid2, busy2, done2, pass2;
    logic [6:0] c2, mask2 = '0;
    logic [6:0] p2 [3] = '{7'd0, 7'd0, 7'd0};
    int dep2 = 3;
    logic [15:0] err2;
`ifdef FIRST_ERR_CAPTURE_EN
    logic fev2; logic [3:0] fea2, feb2; logic [6:0] fec2;
`endif

    adder_stim_checker #(.LATENCY(3), .NUM_VEC(64), .GAP(0)) u2 (
        .clk(clk), .rst(rst2), .start(start2), .mode(mode2),
        .a(a2), .b(b2), .valid(valid2), .c(c2),
        .busy(busy2), .done(done2), .err_cnt(err2), .pass(pass2)
`ifdef FIRST_ERR_CAPTURE_EN
        , .first_err_vld(fev2), .first_err_a(fea2), .first_err_b(feb2), .first_err_c(fec2)
`endif
    );

    always @(posedge clk) begin
        p2[0] <= 7'(a2) + 7'(b2);
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end
    assign c2 = ((dep2 == 3) ? p2[2] : p2[1]) & ~mask2;

    logic md2 = 1'b0; int nv2 = 0;
    always @(negedge clk) begin : mon2
        logic [7:0] v;
        if (valid2) begin
            v = ref_vec(md2, nv2);
            chk("u2 vec", {b2, a2}, v);
            nv2++;
        end
    end

    // ---------------- run helper for instance 0 ----------------
    task automatic run0(input logic m, input logic [6:0] mk, input bit poke_busy);
        @(negedge clk);
        mask0 = mk; md0 = m; nv0 = 0; mode0 = m; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("u0 post-start busy", busy0, 1);
        chk("u0 post-start done", done0, 0);
        chk("u0 post-start err", err0, 0);
        chk("u0 post-start valid", valid0, 1);
        if (poke_busy) begin
            repeat (50) @(negedge clk);
            start0 = 1'b1; mode0 = ~m;
            @(negedge clk);
            start0 = 1'b0;
        end
        for (int i = 0; i < 3000 && !done0; i++) @(negedge clk);
        chk("u0 done reached", done0, 1);
        chk("u0 vector count", nv0, 256);
    endtask

    typedef struct {
        logic       mode;
        logic [6:0] mask;
        int         err;
        logic       pass;
        logic       fe_vld;
        logic [3:0] fe_a;
        logic [3:0] fe_b;
        logic [6:0] fe_c;
    } vec_t;

    initial begin : main
        vec_t tab [4];
        int tdone, e, src;
        logic m;
        logic [6:0] mk, cexp;

        tab[0] = '{1'b0, 7'h00, 0,   1'b1, 1'b0, 4'h0, 4'h0, 7'h00};
        tab[1] = '{1'b0, 7'h01, 128, 1'b0, 1'b1, 4'h1, 4'h0, 7'h00};
        tab[2] = '{1'b1, 7'h00, 0,   1'b1, 1'b0, 4'h0, 4'h0, 7'h00};
        tab[3] = '{1'b0, 7'h10, 120, 1'b0, 1'b1, 4'hF, 4'h1, 7'h00};

        repeat (3) @(negedge clk);
        chk("rst u0 a", a0, 0);         chk("rst u0 b", b0, 0);
        chk("rst u0 valid", valid0, 0); chk("rst u0 busy", busy0, 0);
        chk("rst u0 done", done0, 0);   chk("rst u0 err", err0, 0);
        chk("rst u0 pass", pass0, 0);
        chk("rst u1 valid", valid1, 0); chk("rst u2 busy", busy2, 0);
`ifdef FIRST_ERR_CAPTURE_EN
        chk("rst u0 fe_vld", fev0, 0);
`endif
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle u0 valid", valid0, 0);

        // Table-driven full runs on instance 0.
        for (int i = 0; i < 4; i++) begin
            run0(tab[i].mode, tab[i].mask, 1'b0);
            chk("u0 tab err_cnt", err0, tab[i].err);
            chk("u0 tab pass", pass0, tab[i].pass);
`ifdef FIRST_ERR_CAPTURE_EN
            chk("u0 tab fe_vld", fev0, tab[i].fe_vld);
            if (tab[i].fe_vld) begin
                chk("u0 tab fe_a", fea0, tab[i].fe_a);
                chk("u0 tab fe_b", feb0, tab[i].fe_b);
                chk("u0 tab fe_c", fec0, tab[i].fe_c);
            end
`endif
        end

        // Start while busy must not disturb the stream or relatch mode.
        run0(1'b0, 7'h00, 1'b1);
        chk("u0 busy-start err", err0, 0);
        chk("u0 busy-start pass", pass0, 1);

        // Reset pulse mid-run.
        @(negedge clk);
        mask0 = 7'h01; md0 = 1'b0; nv0 = 0; mode0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (30) @(negedge clk);
        rst0 = 1'b0;
        #1;
        chk("midrst valid", valid0, 0); chk("midrst busy", busy0, 0);
        chk("midrst done", done0, 0);   chk("midrst err", err0, 0);
        chk("midrst a", a0, 0);         chk("midrst b", b0, 0);
        chk("midrst pass", pass0, 0);
`ifdef FIRST_ERR_CAPTURE_EN
        chk("midrst fe_vld", fev0, 0);
`endif
        @(negedge clk);
        rst0 = 1'b1;
        run0(1'b0, 7'h00, 1'b0);
        chk("post-rst err", err0, 0);
        chk("post-rst pass", pass0, 1);

        // Instance 1: LFSR mode with gaps, then exhaustive mode.
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            md1 = (r == 0); mode1 = (r == 0); nv1 = 0; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            tdone = -1;
            for (int i = 0; i < 200 && !done1; i++) @(negedge clk);
            chk("u1 done reached", done1, 1);
            tdone = cyc;
            chk("u1 vector count", nv1, 5);
            chk("u1 done delay", tdone - lv1, 2);
            chk("u1 err", err1, 0);
            chk("u1 pass", pass1, 1);
            if (r == 0) begin
                chk("u1 lfsr v0", cap1[0], 8'h01);
                chk("u1 lfsr v1", cap1[1], 8'h02);
                chk("u1 lfsr v2", cap1[2], 8'h04);
                chk("u1 lfsr v3", cap1[3], 8'h08);
                chk("u1 lfsr v4", cap1[4], 8'h11);
            end
        end

        // Instance 2: randomized mode / model delay / stuck-at faults against a reference count.
        for (int r = 0; r < 8; r++) begin
            m  = (r < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            mk = (r < 2 || $urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom_range(1, 127));
            @(negedge clk);
            dep2 = (r == 0) ? 3 : (r == 1) ? 2 : int'($urandom_range(2, 3));
            mask2 = mk; md2 = m; mode2 = m; nv2 = 0; start2 = 1'b1;
            e = 0;
            for (int k = 0; k < 64; k++) begin
                src  = (dep2 == 3) ? k : ((k + 1 < 64) ? k + 1 : 63);
                cexp = vsum(ref_vec(m, src)) & ~mk;
                if (cexp != vsum(ref_vec(m, k))) e++;
            end
            @(negedge clk);
            start2 = 1'b0;
            for (int i = 0; i < 500 && !done2; i++) @(negedge clk);
            chk("u2 done reached", done2, 1);
            chk("u2 vector count", nv2, 64);
            chk("u2 err_cnt", err2, e);
            chk("u2 pass", pass2, (e == 0) ? 1 : 0);
            if (r == 1) chk("u2 short delay detected", (err2 != 0) ? 1 : 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail + 1);
        $fatal(1, "timeout");
    end

endmodule
